packet_assembler: RTL
=====================

// Module: packet_assembler
// PURPOSE
//  Inverse of the packet disassembler: collects a stream of small val/rdy packets (nbits_in)
//  and emits one large val/rdy packet (nbits_out). The first chunk received is the most
//  significant. Sits on the SPI_v3 receive path, rebuilding wide words from narrow SPI frames.
//  Assembly and output registers are separate, so the next word can assemble while one is held.
// PARAMETERS
//  nbits_in   8   width of each input chunk; must satisfy nbits_in <= nbits_out
//  nbits_out  8   width of assembled output packet
//  num_regs   derived, ceil(nbits_out/nbits_in)   chunks per output packet; not user-set
//  cnt_bits   derived, max(1,$clog2(num_regs))    chunk counter width; not user-set
// PORTS
//  clk       in   1          clock; all state updates on posedge
//  reset     in   1          asynchronous, active-low reset (0 = reset asserted)
//  req_val   in   1          input chunk valid
//  req_rdy   out  1          assembler can accept chunk
//  req_msg   in   nbits_in   input chunk
//  resp_val  out  1          assembled packet valid
//  resp_rdy  in   1          downstream accepts packet
//  resp_msg  out  nbits_out  assembled packet
// BEHAVIOUR
//  Reset (reset==0, async): count=0, chunk regs=0, resp_val=0, resp_msg=0. Held while low.
//  State: count (chunks captured in current word), num_regs-1 chunk regs, output reg + resp_val.
//  Handshakes: req fires when req_val&req_rdy. resp fires when resp_val&resp_rdy.
//  req_rdy = (count != num_regs-1) | ~resp_val | resp_rdy  (combinational path from resp_rdy
//   exists only for the last chunk; non-last chunks are never stalled).
//  Non-last chunk fire (count<num_regs-1): store chunk in slot for position count; count++.
//  Last chunk fire (count==num_regs-1): next-cycle resp_msg = {earlier chunks, req_msg}
//   truncated to nbits_out; resp_val<=1; count<=0. Latency: resp_val high the cycle after
//   the last chunk fires.
//  Bit mapping: chunk k (k=0 first) maps to bits [nbits_out-1-... ] so that the last chunk
//   occupies [nbits_in-1:0], chunk num_regs-2 the next nbits_in bits, etc. Chunk 0 contributes
//   only its low nbits_out-nbits_in*(num_regs-1) bits; its upper bits are discarded.
//  resp fire with no last chunk fire same cycle: resp_val<=0; resp_msg holds value.
//  Simultaneous resp fire and last-chunk fire: new word loaded, resp_val stays 1 (no bubble).
//  Sustained throughput: one output word per num_regs cycles when resp_rdy==1.
//  resp_msg stable while resp_val&~resp_rdy; chunk inputs ignored unless req fires.
//  num_regs==1 (nbits_in==nbits_out): behaves as a one-entry pipeline register, req_rdy=~resp_val|resp_rdy.
//  Reset asserted mid-word or with resp_val high: partial word and held output discarded.
//  count never exceeds num_regs-1; wrap to 0 only on last-chunk fire.
// TESTING
//  in=8,out=16: chunks 0xAB,0xCD back-to-back, resp_rdy=1 -> resp_msg=0xABCD, resp_val 1 cycle after 0xCD.
//  in=8,out=12: chunks 0xFA,0xBC -> resp_msg=0xABC (upper nibble of 0xFA dropped).
//  in=8,out=16, resp_rdy=0: send 0x11,0x22 then 0x33 -> 0x33 accepted, req_rdy=0 on 0x44 until
//   resp_rdy=1; outputs 0x1122 then 0x3344, no loss or duplication.
//  Stream 0x01..0x08 (in=8,out=16) with resp_rdy=1 -> 0x0102,0x0304,0x0506,0x0708, 1 word/2 cycles.
//  Drop reset after 0xAA accepted, then send 0xBB,0xCC -> only output 0xBBCC; resp_val=0, resp_msg=0 in reset.
//  Loopback: disassembler(16->8) feeding assembler(8->16), random 0x0000-0xFFFF -> identical words out.

Source files
------------

// File: rtl/packet_assembler.sv
// Packet assembler: gathers nbits_in-wide chunks, first chunk most significant, into one
// nbits_out-wide word, with a separate output register so the next word can assemble meanwhile.
module packet_assembler #(
    parameter int nbits_in  = 8,
    parameter int nbits_out = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [nbits_in-1:0]  req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [nbits_out-1:0] resp_msg
);

    localparam int NumRegs = (nbits_out + nbits_in - 1) / nbits_in;
    localparam int CntBits = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam int AccW    = nbits_out - nbits_in;
    localparam logic [CntBits-1:0] LastCnt = CntBits'(NumRegs - 1);

    logic [CntBits-1:0]   countQ, countD;
    logic                 respValQ, respValD;
    logic [nbits_out-1:0] respMsgQ, respMsgD;
    logic [nbits_out-1:0] assembled;
    logic                 isLast, reqRdy, reqFire, respFire, lastFire;

    assign isLast   = (countQ == LastCnt);
    assign reqRdy   = !isLast || !respValQ || resp_rdy;
    assign reqFire  = req_val && reqRdy;
    assign respFire = respValQ && resp_rdy;
    assign lastFire = reqFire && isLast;

    assign req_rdy  = reqRdy;
    assign resp_val = respValQ;
    assign resp_msg = respMsgQ;

    // Earlier chunks live in a shift register sized to just the bits that survive into
    // the output word, so chunk 0's discarded upper bits fall off the top as it shifts.
    if (AccW == 0) begin : gNoAcc
        assign assembled = req_msg;
    end else begin : gAcc
        logic [AccW-1:0] accQ, accD;

        if (AccW > nbits_in) begin : gWide
            assign accD = {accQ[AccW-nbits_in-1:0], req_msg};
        end else begin : gNarrow
            assign accD = req_msg[AccW-1:0];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                accQ <= '0;
            end else if (reqFire && !isLast) begin
                accQ <= accD;
            end
        end

        assign assembled = {accQ, req_msg};
    end

    always_comb begin
        countD   = countQ;
        respValD = respValQ;
        respMsgD = respMsgQ;
        if (lastFire) begin
            countD   = '0;
            respValD = 1'b1;
            respMsgD = assembled;
        end else begin
            if (reqFire) begin
                countD = countQ + CntBits'(1);
            end
            if (respFire) begin
                respValD = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countQ   <= '0;
            respValQ <= 1'b0;
            respMsgQ <= '0;
        end else begin
            countQ   <= countD;
            respValQ <= respValD;
            respMsgQ <= respMsgD;
        end
    end

endmodule
